sram_2rw_param: RTL
===================

Name: sram_2rw_param

Overview:
- Parametrised behavioural two-port read/write SRAM. It is the next generation of the fixed-size SRAM2RW macro models.
- Adds the following on top of the fixed macros: generic depth and width, per-lane write mask, selectable read latency, a defined collision policy, and a hardware clear sequence after reset.
- Used as the simulation and synthesis-fallback model behind cache and tag arrays where no hardened macro exists.

Parameters:
- DEPTH, 32, number of words; must be ≥2; need not be a power of two.
- WIDTH, 22, bits per word.
- LANE_W, 11, write-mask granularity in bits; WIDTH must be a multiple of LANE_W.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2. A value of 2 adds an output register stage.
- AW, $clog2(DEPTH), address width (derived).
- NL, WIDTH/LANE_W, number of mask lanes (derived).

Ports:
- clock  in  1  single clock; both ports sample on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en1  in  1  port 1 access enable, active high.
- we1  in  1  port 1 write when 1, read when 0 (qualified by en1).
- addr1  in  AW  port 1 address.
- wmask1  in  NL  port 1 lane write enables.
- wdata1  in  WIDTH  port 1 write data.
- rdata1  out  WIDTH  port 1 read data.
- rvalid1  out  1  port 1 read data valid, one-cycle pulse.
- en2, we2, addr2, wmask2, wdata2, rdata2, rvalid2: identical definitions for port 2.
- init_done  out  1  high once the clear sweep has completed.
- collision  out  1  one-cycle pulse on a same-address conflict.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - rdata1/2=0, rvalid1/2=0, init_done=0, collision=0.
  - Init FSM enters CLEAR with its pointer at 0.
  - Memory contents are not reset asynchronously.
- Init FSM states are CLEAR and READY:
  - CLEAR: one word is written to all-zero per cycle at the pointer, and the pointer increments.
  - When the pointer reaches DEPTH-1 and that word is written, the FSM goes to READY.
  - init_done rises on the cycle after the last clear write. The clear therefore takes exactly DEPTH cycles after reset release.
  - READY is terminal until the next reset.
  - While in CLEAR, en1/en2 are ignored: no writes, rvalid stays 0, collision stays 0.
- Write (READY, en=1, we=1):
  - Lanes with wmask[k]=1 take wdata at the clock edge; other lanes keep their old value.
  - wmask=0 performs no write but still counts as an access.
- Read (READY, en=1, we=0):
  - READ_LAT=1: rdata/rvalid update at the edge after the request.
  - READ_LAT=2: they update one edge later.
  - rdata holds its last value when no read completes. rvalid is 1 only in the cycle the data is new.
- Address out of range (addr ≥ DEPTH):
  - A write is dropped.
  - A read returns 0 with rvalid=1.
- Same-port read-during-write cannot occur, because we selects read or write.
- Cross-port same address, both en=1, READY:
  - Write + write: lanes where both masks are set take port 1 data. Other lanes take whichever port's mask is set. collision pulses the next cycle.
  - Read on one port + write on the other: the read returns the pre-write (old) word. collision pulses.
  - Read + read: both return the same word. No collision.
- Port timing: both ports are fully independent and pipelined, so a new request is accepted every cycle on each port.
- Reset mid-operation:
  - In-flight reads are discarded and rvalid does not fire.
  - A mid-sweep reset restarts CLEAR at pointer 0.

Decomposition:
- Shared package sram_pkg:
  - clear-FSM state enum {CLEAR, READY};
  - function lane_merge(old, new, mask);
  - localparam checks: LANE_W divides WIDTH, and READ_LAT ∈ {1,2}.
- One sub-module, sram_rd_pipe: per-port read-data/valid register chain of depth READ_LAT with async reset. It is instantiated twice.
- Memory array, collision resolution and the clear FSM live in the top module.

Test Plan:
- Reset release with DEPTH=32 → init_done rises exactly 32 cycles later. Accesses issued during that window are ignored: rvalid=0, and the target words still read 0 afterward.
- Port 1 writes 0x3FFFFF to addr 5 with wmask=2'b01, then port 2 reads addr 5 → rdata2=0x0007FF with rvalid2 pulsing at +1 cycle. With READ_LAT=2 the same pulse arrives at +2.
- Same cycle: port 1 writes 0x1 and port 2 writes 0x2 to addr 7, full masks → addr 7 reads 0x1 and collision pulses once. Repeat with wmask1=2'b10, wmask2=2'b01 → result is {lane1 from port 1, lane0 from port 2}.
- Addr 3 holds 0xA; same cycle, port 1 reads addr 3 while port 2 writes 0xB to addr 3 → rdata1=0xA, collision=1; the next read returns 0xB.
- Back-to-back reads on both ports to addrs 0..31 for 32 cycles → rvalid is high continuously and data matches the reference array. Reset asserted mid-stream → outputs go to 0 immediately and CLEAR restarts.
- DEPTH=24: read addr 30 → rdata=0, rvalid=1. A write to addr 30 leaves all 24 words unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised two-port SRAM model.
// Provides the clear-FSM state enum, lane merge and a parameter check.
package sram_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } init_state_t;

    // Widest word / most lanes the generic merge helper handles.
    localparam int MAX_W  = 256;
    localparam int MAX_NL = 256;

    // Replace the lanes of old_w selected by mask with the same lanes of new_w.
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_NL-1:0] mask,
        input int                lane_w
    );
        logic [MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_W; i++) begin
            if (mask[i / lane_w]) r[i] = new_w[i];
        end
        return r;
    endfunction

    // Legal configuration: lanes tile the word, latency 1 or 2, >=2 words.
    function automatic bit cfg_ok(
        input int depth,
        input int width,
        input int lane_w,
        input int read_lat
    );
        return (depth >= 2) && (lane_w > 0) && (width > 0) &&
               (width <= MAX_W) && (width % lane_w == 0) &&
               (width / lane_w <= MAX_NL) &&
               (read_lat == 1 || read_lat == 2);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Per-port read data/valid register chain of depth LAT.
// Ports: clock, reset_n, in_valid/in_data (captured read), out_valid/out_data.
module sram_rd_pipe #(
    parameter int WIDTH = 22,
    parameter int LAT   = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LAT-1:0]            v_q;
    logic [LAT-1:0][WIDTH-1:0] d_q;

    // Data only moves with its valid bit, so the output holds between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q[0] <= in_valid;
            if (in_valid) d_q[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) d_q[i] <= d_q[i-1];
            end
        end
    end

    assign out_valid = v_q[LAT-1];
    assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/sram_2rw_param.sv
// Behavioural two-port read/write SRAM with lane masks, clear sweep and collisions.
// Ports: clock, reset_n; per port en/we/addr/wmask/wdata -> rdata/rvalid; init_done, collision.
module sram_2rw_param
    import sram_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int WIDTH    = 22,
    parameter int LANE_W   = 11,
    parameter int READ_LAT = 1,
    parameter int AW       = $clog2(DEPTH),
    parameter int NL       = WIDTH / LANE_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en1,
    input  logic             we1,
    input  logic [AW-1:0]    addr1,
    input  logic [NL-1:0]    wmask1,
    input  logic [WIDTH-1:0] wdata1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid1,
    input  logic             en2,
    input  logic             we2,
    input  logic [AW-1:0]    addr2,
    input  logic [NL-1:0]    wmask2,
    input  logic [WIDTH-1:0] wdata2,
    output logic [WIDTH-1:0] rdata2,
    output logic             rvalid2,
    output logic             init_done,
    output logic             collision
);

    if (!cfg_ok(DEPTH, WIDTH, LANE_W, READ_LAT)) begin : g_bad_cfg
        $error("sram_2rw_param: illegal parameter set");
    end

    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    init_state_t   state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          ready;

    logic             in1, in2, same;
    logic             rd1, rd2, wr1, wr2, both_wr;
    logic [WIDTH-1:0] rword1, rword2;
    logic [WIDTH-1:0] m1, m2, w2;
    logic             coll_q;

    assign ready = (state == READY);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        unique case (state)
            CLEAR: begin
                if (ptr == LAST) state_n = READY;
                else             ptr_n   = ptr + AW'(1);
            end
            READY: ;
        endcase
    end

    assign in1  = {1'b0, addr1} < DEPTH_V;
    assign in2  = {1'b0, addr2} < DEPTH_V;
    assign same = (addr1 == addr2);

    assign rd1 = ready & en1 & ~we1;
    assign rd2 = ready & en2 & ~we2;
    assign wr1 = ready & en1 & we1 & in1;
    assign wr2 = ready & en2 & we2 & in2;
    assign both_wr = wr1 & wr2 & same;

    // Reads sample the array before this edge's writes land: old data wins.
    assign rword1 = in1 ? mem[addr1] : '0;
    assign rword2 = in2 ? mem[addr2] : '0;

    assign m1 = WIDTH'(lane_merge(MAX_W'(rword1), MAX_W'(wdata1),
                                  MAX_NL'(wmask1), LANE_W));
    assign m2 = WIDTH'(lane_merge(MAX_W'(rword2), MAX_W'(wdata2),
                                  MAX_NL'(wmask2), LANE_W));
    // Same-address double write: port 1 lanes are layered over port 2.
    assign w2 = both_wr
        ? WIDTH'(lane_merge(MAX_W'(m2), MAX_W'(wdata1),
                            MAX_NL'(wmask1), LANE_W))
        : m2;

    always_ff @(posedge clock) begin
        if (!ready) begin
            mem[ptr] <= '0;
        end else begin
            if (wr1 && !both_wr) mem[addr1] <= m1;
            if (wr2)             mem[addr2] <= w2;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) coll_q <= 1'b0;
        else          coll_q <= ready & en1 & en2 & same & (we1 | we2);
    end

    sram_rd_pipe #(.WIDTH(WIDTH), .LAT(READ_LAT)) u_rd1 (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (rd1),
        .in_data  (rword1),
        .out_valid(rvalid1),
        .out_data (rdata1)
    );

    sram_rd_pipe #(.WIDTH(WIDTH), .LAT(READ_LAT)) u_rd2 (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (rd2),
        .in_data  (rword2),
        .out_valid(rvalid2),
        .out_data (rdata2)
    );

    assign init_done = ready;
    assign collision = coll_q;

endmodule
